// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the instruction fetch port
//   (I) and the load/store port (D). Only one transaction is in flight at a
//   time. D has priority over I. After STARVE_MAX consecutive D grants while
//   I was waiting, I is forced through. A taken-branch flush cancels an
//   in-flight fetch so that its response is never delivered.
//
//   Ports
//     clk, rst                      clock, asynchronous active-high reset
//     i_req_valid/ready/addr        fetch request handshake
//     i_flush                       cancel in-flight fetch, blocks new fetch
//     i_rsp_valid/data              fetch response (1-cycle pulse)
//     d_req_valid/ready/we/addr/wdata  load/store request handshake
//     d_rsp_valid/data              load data / store completion (1-cycle pulse)
//     mem_en/we/addr/wdata, mem_rdata  memory interface (MEM_LAT read latency)
//     busy                          a transaction is in progress
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_flush,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LAST   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_starve;
  logic [CW-1:0]     r_lat_cnt;
  logic              r_cancel;
  logic              r_owner_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_i_rsp_valid;
  logic [DATA_W-1:0] r_i_rsp_data;
  logic              r_d_rsp_valid;
  logic [DATA_W-1:0] r_d_rsp_data;

  logic w_idle;
  logic w_i_elig;
  logic w_starved;
  logic w_d_win;
  logic w_i_grant;
  logic w_d_grant;
  logic w_last_wait;

  // Arbitration: a flushing fetch is not eligible; D wins unless I is starved.
  assign w_idle      = (r_state == S_IDLE) && !rst;
  assign w_i_elig    = i_req_valid && !i_flush;
  assign w_starved   = (r_starve == STARVE_TOP);
  assign w_d_win     = d_req_valid && !(w_i_elig && w_starved);
  assign d_req_ready = w_idle && w_d_win;
  assign i_req_ready = w_idle && w_i_elig && !w_d_win;
  assign w_d_grant   = d_req_valid && d_req_ready;
  assign w_i_grant   = i_req_valid && i_req_ready;
  assign w_last_wait = (r_state == S_WAIT) && (r_lat_cnt == LAT_LAST);

  assign busy        = (r_state != S_IDLE);
  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      S_IDLE:   if (w_i_grant || w_d_grant) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        w_state_nxt = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT:   if (w_last_wait) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch: captured on the handshake, consumed in ACCESS.
  always_ff @(posedge clk) begin
    if (w_i_grant || w_d_grant) begin
      r_owner_d <= w_d_grant;
      r_we      <= w_d_grant && d_req_we;
      r_addr    <= w_d_grant ? d_req_addr : i_req_addr;
      r_wdata   <= d_req_wdata;
    end
  end

  // Control and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_starve      <= '0;
      r_lat_cnt     <= '0;
      r_cancel      <= 1'b0;
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;

      if (w_i_grant) begin
        r_starve <= '0;
      end else if (w_d_grant) begin
        if (!i_req_valid)    r_starve <= '0;
        else if (!w_starved) r_starve <= r_starve + SW'(1);
      end

      // Cancel lives only for the duration of the fetch it belongs to.
      if (w_state_nxt == S_IDLE)                          r_cancel <= 1'b0;
      else if (r_state != S_IDLE && !r_owner_d && i_flush) r_cancel <= 1'b1;

      if (r_state == S_ACCESS)    r_lat_cnt <= '0;
      else if (r_state == S_WAIT) r_lat_cnt <= r_lat_cnt + CW'(1);

      if (r_state == S_ACCESS && r_we) begin
        r_d_rsp_valid <= 1'b1;
        r_d_rsp_data  <= '0;
      end

      // A flush arriving in the final wait cycle also kills the fetch.
      if (w_last_wait) begin
        if (r_owner_d) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= mem_rdata;
        end else if (!r_cancel && !i_flush) begin
          r_i_rsp_valid <= 1'b1;
          r_i_rsp_data  <= mem_rdata;
        end
      end
    end
  end

endmodule
